// File: rtl/block_fetch_2x_pkg.sv
// Shared types for the 2x block fetcher: FSM state encoding, the
// sub-pixel index within a 2x2 block, and the block size.
package block_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    OUT,
    DONE
  } state_t;

  typedef logic [1:0] sub_idx_t;

  localparam int PIX_PER_BLOCK = 4;

endpackage

// File: rtl/block_fetch_2x_if.sv
// Memory-read and pixel-stream bundle between the block fetcher (master)
// and the frame memory / averager side (slave).
interface block_fetch_2x_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rdata;
  logic [7:0]        pixel_out;
  logic              pixel_valid;
  logic              pixel_ready;
  logic              block_last;
  logic [ADDR_W-2:0] dst_addr;

  modport master (
    output mem_addr, mem_rd_en, pixel_out, pixel_valid, block_last, dst_addr,
    input  mem_rdata, pixel_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, pixel_out, pixel_valid, block_last, dst_addr,
    output mem_rdata, pixel_ready
  );
endinterface

// File: rtl/block_addr_gen.sv
// Block walker: tracks the top-left address of the current 2x2 block,
// the block column/row, the sub-pixel index and the destination index.
// Produces the source address of the current sub-pixel.
module block_addr_gen
  import block_fetch_pkg::*;
#(
  parameter int SRC_WIDTH  = 320,
  parameter int SRC_HEIGHT = 240,
  parameter int ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              block_last,
  output logic              frame_last,
  output logic [ADDR_W-2:0] dst_addr
);

  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO_A     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(SRC_WIDTH);
  localparam logic [ADDR_W-1:0] PAIR_STEP = ADDR_W'(SRC_WIDTH + 2);
  localparam logic [ADDR_W-2:0] ONE_D     = (ADDR_W-1)'(1);
  localparam logic [ADDR_W-2:0] BX_LAST   = (ADDR_W-1)'(SRC_WIDTH / 2 - 1);
  localparam logic [ADDR_W-2:0] BY_LAST   = (ADDR_W-1)'(SRC_HEIGHT / 2 - 1);
  localparam sub_idx_t          K_LAST    = sub_idx_t'(PIX_PER_BLOCK - 1);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-2:0] bx;
  logic [ADDR_W-2:0] by;
  logic [ADDR_W-2:0] dst;
  sub_idx_t          k;
  logic [ADDR_W-1:0] offset;

  // Sub-pixel offset inside the block: TL, TR, BL, BR
  always_comb begin
    offset = '0;
    case (k)
      2'd0:    offset = '0;
      2'd1:    offset = ONE_A;
      2'd2:    offset = ROW_STEP;
      default: offset = ROW_STEP + ONE_A;
    endcase
  end

  assign mem_addr   = base + offset;
  assign block_last = (k == K_LAST);
  assign frame_last = (bx == BX_LAST) && (by == BY_LAST);
  assign dst_addr   = dst;

  // Walk sub-pixels, then blocks along a row-pair, then row-pairs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base <= '0;
      bx   <= '0;
      by   <= '0;
      dst  <= '0;
      k    <= '0;
    end else if (clear) begin
      base <= '0;
      bx   <= '0;
      by   <= '0;
      dst  <= '0;
      k    <= '0;
    end else if (advance) begin
      if (k != K_LAST) begin
        k <= k + 2'd1;
      end else begin
        k   <= '0;
        dst <= dst + ONE_D;
        if (bx == BX_LAST) begin
          // Jump from the last block of this row-pair to column 0 two rows down
          base <= base + PAIR_STEP;
          bx   <= '0;
          by   <= by + ONE_D;
        end else begin
          base <= base + TWO_A;
          bx   <= bx + ONE_D;
        end
      end
    end
  end

endmodule

// File: rtl/block_fetch_2x.sv
// 2x2 block fetcher feeding the 2x averaging downscaler. Reads each block's
// four pixels one byte at a time and streams them with a valid/ready
// handshake, tagged with the destination pixel index.
// Optional feature: define BLOCK_FETCH_ABORT_EN to add an `abort` input.
module block_fetch_2x
  import block_fetch_pkg::*;
#(
  parameter int SRC_WIDTH  = 320,
  parameter int SRC_HEIGHT = 240,
  parameter int ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef BLOCK_FETCH_ABORT_EN
  input  logic              abort,
`endif
  block_fetch_2x_if.master  bus,
  output logic              busy,
  output logic              done
);

  if ((SRC_WIDTH % 2) != 0 || (SRC_HEIGHT % 2) != 0) begin : g_bad_dims
    $error("block_fetch_2x: SRC_WIDTH and SRC_HEIGHT must both be even");
  end

  state_t            state;
  logic              abort_req;
  logic              xfer;
  logic              gen_clear;
  logic              gen_advance;
  logic              gen_block_last;
  logic              gen_frame_last;
  logic [ADDR_W-1:0] gen_addr;
  logic [ADDR_W-2:0] gen_dst;

`ifdef BLOCK_FETCH_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign xfer        = bus.pixel_valid & bus.pixel_ready;
  assign gen_clear   = (state == IDLE) && start;
  // The final block leaves the walker untouched so dst_addr holds its last value
  assign gen_advance = (state == OUT) && xfer && !abort_req &&
                       !(gen_block_last && gen_frame_last);

  block_addr_gen #(
    .SRC_WIDTH (SRC_WIDTH),
    .SRC_HEIGHT(SRC_HEIGHT),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clear     (gen_clear),
    .advance   (gen_advance),
    .mem_addr  (gen_addr),
    .block_last(gen_block_last),
    .frame_last(gen_frame_last),
    .dst_addr  (gen_dst)
  );

  assign bus.mem_addr = gen_addr;
  assign bus.dst_addr = gen_dst;

  // Frame FSM with registered strobes, pixel register and handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      bus.mem_rd_en   <= 1'b0;
      bus.pixel_out   <= '0;
      bus.pixel_valid <= 1'b0;
      bus.block_last  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_req && state != IDLE) begin
        state           <= IDLE;
        bus.mem_rd_en   <= 1'b0;
        bus.pixel_valid <= 1'b0;
        bus.block_last  <= 1'b0;
        busy            <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state         <= READ;
              bus.mem_rd_en <= 1'b1;
              busy          <= 1'b1;
            end
          end
          READ: begin
            bus.mem_rd_en <= 1'b0;
            state         <= WAIT;
          end
          WAIT: begin
            bus.pixel_out   <= bus.mem_rdata;
            bus.pixel_valid <= 1'b1;
            bus.block_last  <= gen_block_last;
            state           <= OUT;
          end
          OUT: begin
            if (xfer) begin
              bus.pixel_valid <= 1'b0;
              bus.block_last  <= 1'b0;
              if (gen_block_last && gen_frame_last) begin
                state <= DONE;
              end else begin
                state         <= READ;
                bus.mem_rd_en <= 1'b1;
              end
            end
          end
          DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_block_fetch_2x.sv
// Directed bench for block_fetch_2x: a 4x4 instance and a 2x2 instance,
// each backed by a memory whose data equals its address.
module tb_block_fetch_2x;

  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;
  logic ready;
  logic sel;
  logic start_a, start_b;
  logic busy_a, done_a, busy_b, done_b;
`ifdef BLOCK_FETCH_ABORT_EN
  logic abort_a;
  logic abort_b;
`endif

  block_fetch_2x_if #(.ADDR_W(AW)) a_if ();
  block_fetch_2x_if #(.ADDR_W(AW)) b_if ();

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign a_if.pixel_ready = ready;
  assign b_if.pixel_ready = ready;

  // Source frame memories: data = address, one-cycle read latency
  always @(posedge clk) begin
    if (a_if.mem_rd_en) a_if.mem_rdata <= a_if.mem_addr;
    if (b_if.mem_rd_en) b_if.mem_rdata <= b_if.mem_addr;
  end

  block_fetch_2x #(.SRC_WIDTH(4), .SRC_HEIGHT(4), .ADDR_W(AW)) dut_a (
    .clk  (clk),
    .reset(reset),
    .start(start_a),
`ifdef BLOCK_FETCH_ABORT_EN
    .abort(abort_a),
`endif
    .bus  (a_if),
    .busy (busy_a),
    .done (done_a)
  );

  block_fetch_2x #(.SRC_WIDTH(2), .SRC_HEIGHT(2), .ADDR_W(AW)) dut_b (
    .clk  (clk),
    .reset(reset),
    .start(start_b),
`ifdef BLOCK_FETCH_ABORT_EN
    .abort(abort_b),
`endif
    .bus  (b_if),
    .busy (busy_b),
    .done (done_b)
  );

  // Observation mux over the selected instance
  logic [7:0] o_addr, o_pix;
  logic [6:0] o_dst;
  logic       o_rd, o_vld, o_last, o_busy, o_done;
  always_comb begin
    if (sel) begin
      o_addr = b_if.mem_addr;  o_pix = b_if.pixel_out;  o_dst = b_if.dst_addr;
      o_rd = b_if.mem_rd_en;   o_vld = b_if.pixel_valid; o_last = b_if.block_last;
      o_busy = busy_b;         o_done = done_b;
    end else begin
      o_addr = a_if.mem_addr;  o_pix = a_if.pixel_out;  o_dst = a_if.dst_addr;
      o_rd = a_if.mem_rd_en;   o_vld = a_if.pixel_valid; o_last = a_if.block_last;
      o_busy = busy_a;         o_done = done_a;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  int e4[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  int e2[4]  = '{0, 1, 2, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input bit b, input int i);
    if (b) return (i < 4) ? e2[i] : -1;
    return (i < 16) ? e4[i] : -1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_rd"}, o_rd, 0);
    chk({tag, "_pix"}, o_pix, 0);
    chk({tag, "_vld"}, o_vld, 0);
    chk({tag, "_last"}, o_last, 0);
    chk({tag, "_dst"}, o_dst, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  // Runs one frame from the current negedge; rel is the cycle index after the start edge
  task automatic run_frame(input bit b, input int bp_idx, input int pulse_at,
                           input int exp_done);
    int n, rel, s, xfers, reads, dones, done_at, stall, iter;
    logic [7:0] snap_pix;
    logic       snap_last;
    logic [6:0] snap_dst;
    logic       r;
    n = b ? 4 : 16;
    xfers = 0; reads = 0; dones = 0; done_at = -1; stall = 0; iter = 0;
    snap_pix = '0; snap_last = 1'b0; snap_dst = '0;
    sel = b;
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
    while (iter < 300) begin
      rel = cyc - s + 1;
      start = 1'b0;
      if (rel == 1) chk("busy_rd1", o_busy, 1);
      if (o_rd) begin
        chk($sformatf("rd_addr%0d", reads), o_addr, exp_addr(b, reads));
        reads++;
      end
      r = 1'b1;
      if (o_vld && xfers == bp_idx && stall < 5) begin
        if (stall == 0) begin
          snap_pix = o_pix; snap_last = o_last; snap_dst = o_dst;
        end else begin
          chk("stall_pix", o_pix, snap_pix);
          chk("stall_last", o_last, snap_last);
          chk("stall_dst", o_dst, snap_dst);
          chk("stall_vld", o_vld, 1);
        end
        chk("stall_rd", o_rd, 0);
        r = 1'b0;
        stall++;
      end
      ready = r;
      if (o_vld && r) begin
        chk($sformatf("pix%0d", xfers), o_pix, exp_addr(b, xfers));
        chk($sformatf("last%0d", xfers), o_last, (xfers % 4) == 3);
        chk($sformatf("dst%0d", xfers), o_dst, xfers / 4);
        xfers++;
      end
      if (pulse_at >= 0 && rel == pulse_at) start = 1'b1;
      if (o_done) begin
        dones++;
        if (dones == 1) begin
          done_at = rel;
          chk("busy_at_done", o_busy, 0);
        end
      end
      if (dones > 0 && rel >= done_at + 4) break;
      iter++;
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b1;
    chk("xfer_count", xfers, n);
    chk("read_count", reads, n);
    chk("done_count", dones, 1);
    chk("done_cycle", done_at, exp_done);
    if (bp_idx >= 0) chk("stall_cycles", stall, 5);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ready = 1'b1; sel = 1'b0;
`ifdef BLOCK_FETCH_ABORT_EN
    abort_a = 1'b0; abort_b = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_all_zero("rst_a");
    sel = 1'b1;
    #1 check_all_zero("rst_b");
    sel = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", o_busy, 0);

    // Plain 4x4 frame, pixel_ready tied high
    run_frame(1'b0, -1, -1, 50);
    @(negedge clk);
    chk("after_frame_dst", o_dst, 3);

    // Backpressure on the second pixel
    run_frame(1'b0, 1, -1, 55);
    @(negedge clk);

    // Spurious start mid-frame
    run_frame(1'b0, -1, 10, 50);
    @(negedge clk);

    // Reset during WAIT of the second block (cycle 14)
    sel = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_rst_dst", o_dst, 1);
    chk("pre_rst_pix", o_pix, 5);
    reset = 1'b1;
    #1 check_all_zero("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", o_busy, 0);
    run_frame(1'b0, -1, -1, 50);
    @(negedge clk);

    // Minimum 2x2 image
    run_frame(1'b1, -1, -1, 14);
    @(negedge clk);
    sel = 1'b0;

`ifdef BLOCK_FETCH_ABORT_EN
    begin
      int dones;
      dones = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_vld_before", o_vld, 1);
      abort_a = 1'b1;
      ready = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      chk("abort_busy", o_busy, 0);
      chk("abort_vld", o_vld, 0);
      chk("abort_rd", o_rd, 0);
      for (int i = 0; i < 60; i++) begin
        if (o_done) dones++;
        @(negedge clk);
      end
      chk("abort_no_done", dones, 0);
      run_frame(1'b0, -1, -1, 50);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
